// File: rtl/apb_sl_req_arbiter.sv
// Two-requester APB master arbiter for the serial-link bridge register port.
// Round-robin grant, one outstanding transfer, ACCESS-phase timeout guard.
module apb_sl_req_arbiter #(
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_CNT_WIDTH   = 5
) (
    input  logic                    pclk,
    input  logic                    preset_n,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_write,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [63:0]             req_wdata,
    input  logic [7:0]              req_strb,
    output logic [1:0]              rsp_valid,
    output logic [31:0]             rsp_rdata,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    owner,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [31:0]             pwdata,
    output logic [3:0]              pstrb,
    input  logic                    pready,
    input  logic [31:0]             prdata,
    input  logic                    pslverr,
    output logic [1:0]              state_dbg
);

    // Handshake: a request transfers in the cycle where req_valid[i] && req_ready[i];
    // req_ready is only ever raised in IDLE, for the arbitration winner alone.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TO_CNT_WIDTH-1:0] TO_LAST = TO_LAST_I[TO_CNT_WIDTH-1:0];

    state_t                  state;
    state_t                  state_next;
    logic                    last_grant;
    logic [TO_CNT_WIDTH-1:0] to_cnt;
    logic                    winner;
    logic                    grant;
    logic                    done;
    logic                    timed_out;

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_comb begin
        state_next = state;
        req_ready  = 2'b00;
        winner     = 1'b0;
        grant      = 1'b0;
        done       = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    // On contention the requester not served last time wins.
                    winner     = (&req_valid) ? ~last_grant : req_valid[1];
                    grant      = 1'b1;
                    req_ready  = winner ? 2'b10 : 2'b01;
                    state_next = SETUP;
                end
            end
            SETUP: state_next = ACCESS;
            ACCESS: begin
                timed_out = (TIMEOUT_CYCLES > 0) && !pready && (to_cnt == TO_LAST);
                done      = pready || timed_out;
                if (done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) state <= IDLE;
        else           state <= state_next;
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
            pstrb      <= '0;
            rsp_valid  <= 2'b00;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            to_cnt     <= '0;
        end else begin
            rsp_valid <= 2'b00;
            if (grant) begin
                owner      <= winner;
                last_grant <= winner;
                psel       <= 1'b1;
                penable    <= 1'b0;
                pwrite     <= winner ? req_write[1] : req_write[0];
                paddr      <= winner ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
                pwdata     <= winner ? req_wdata[63:32] : req_wdata[31:0];
                pstrb      <= winner ? req_strb[7:4] : req_strb[3:0];
            end
            if (state == SETUP) begin
                penable <= 1'b1;
                to_cnt  <= '0;
            end
            if (state == ACCESS) begin
                if (done) begin
                    psel      <= 1'b0;
                    penable   <= 1'b0;
                    rsp_valid <= owner ? 2'b10 : 2'b01;
                    // Timeouts and writes return zero data; pslverr only counts with pready.
                    rsp_rdata <= (pready && !pwrite) ? prdata : 32'h0;
                    rsp_err   <= timed_out | (pready & pslverr);
                end else if ((TIMEOUT_CYCLES > 0) && (to_cnt != TO_LAST)) begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_sl_req_arbiter.sv
// Bench for apb_sl_req_arbiter: directed scenarios plus random traffic, all
// checked each cycle against a transaction-level model of the arbiter.
module tb_apb_sl_req_arbiter;

    localparam int AW = 10;
    localparam int TO = 16;

    logic          pclk;
    logic          preset_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [1:0]    req_write;
    logic [2*AW-1:0] req_addr;
    logic [63:0]   req_wdata;
    logic [7:0]    req_strb;
    logic [1:0]    rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          busy;
    logic          owner;
    logic [AW-1:0] paddr;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [31:0]   pwdata;
    logic [3:0]    pstrb;
    logic          pready;
    logic [31:0]   prdata;
    logic          pslverr;
    logic [1:0]    state_dbg;

    apb_sl_req_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO), .TO_CNT_WIDTH(5)) dut (
        .pclk(pclk), .preset_n(preset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .owner(owner),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .state_dbg(state_dbg)
    );

    // Clock / reset
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_chk = 0;
    int n_err = 0;

    // Transaction-level model: age counts cycles since the grant
    // (1 = setup phase, 2.. = access phase).
    bit            m_active;
    int            m_age;
    logic          m_owner;
    logic          m_last;
    logic          m_wr;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [3:0]    m_strb;
    logic [1:0]    m_rsp_v;
    logic [1:0]    m_acc;
    logic [32:0]   exp_q[$];   // {err, rdata} of each predicted completion

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        m_active = 1'b0; m_age = 0; m_owner = 1'b0; m_last = 1'b1; m_wr = 1'b0;
        m_addr = '0; m_wdata = '0; m_strb = '0; m_rsp_v = 2'b00; m_acc = 2'b00;
        exp_q.delete();
    endtask

    task automatic set_req(input int i, input logic v, input logic w, input logic [AW-1:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        req_valid[i]           = v;
        req_write[i]           = w;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*32 +: 32]  = d;
        req_strb[i*4 +: 4]     = s;
    endtask

    // Inputs for this cycle are already driven; check outputs, advance the model,
    // then step to just after the next rising edge.
    task automatic cycle();
        logic [1:0]  exp_rdy;
        int          win;
        logic [32:0] e;
        #1;
        exp_rdy = 2'b00;
        win = 0;
        if (!m_active && req_valid != 2'b00) begin
            if (req_valid == 2'b11) win = m_last ? 0 : 1;
            else                    win = req_valid[1] ? 1 : 0;
            exp_rdy[win] = 1'b1;
        end
        check("req_ready", req_ready, exp_rdy);
        check("psel", psel, m_active);
        check("penable", penable, m_active && m_age >= 2);
        check("busy", busy, m_active);
        check("owner", owner, m_owner);
        check("paddr", paddr, m_addr);
        check("pwrite", pwrite, m_wr);
        check("pwdata", pwdata, m_wdata);
        check("pstrb", pstrb, m_strb);
        check("rsp_valid", rsp_valid, m_rsp_v);
        if (m_rsp_v != 2'b00 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rsp_err", rsp_err, e[32]);
            check("rsp_rdata", rsp_rdata, e[31:0]);
        end

        m_rsp_v = 2'b00;
        m_acc   = exp_rdy;
        if (!m_active) begin
            if (exp_rdy != 2'b00) begin
                m_active = 1'b1;
                m_age    = 1;
                m_owner  = (win == 1);
                m_last   = (win == 1);
                m_wr     = req_write[win];
                m_addr   = req_addr[win*AW +: AW];
                m_wdata  = req_wdata[win*32 +: 32];
                m_strb   = req_strb[win*4 +: 4];
            end
        end else if (m_age == 1) begin
            m_age = 2;
        end else if (pready || (m_age - 2 == TO - 1)) begin
            if (pready) exp_q.push_back({pslverr, (m_wr ? 32'h0 : prdata)});
            else        exp_q.push_back({1'b1, 32'h0});
            m_rsp_v  = m_owner ? 2'b10 : 2'b01;
            m_active = 1'b0;
        end else begin
            m_age++;
        end
        @(posedge pclk);
        #1;
    endtask

    task automatic drive_random(input bit stall);
        for (int i = 0; i < 2; i++) begin
            if (req_valid[i] && !m_acc[i]) begin
                if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                set_req(i, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 1023)),
                        $urandom, 4'($urandom_range(0, 15)));
            end else begin
                req_valid[i] = 1'b0;
            end
        end
        pready  = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
        prdata  = $urandom;
        pslverr = ($urandom_range(0, 5) == 0);
    endtask

    initial begin
        preset_n = 1'b0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
        pready = 1'b0; prdata = '0; pslverr = 1'b0;
        reset_model();
        repeat (3) @(posedge pclk);
        #1;
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_paddr", paddr, 0);
        preset_n = 1'b1;
        @(posedge pclk);
        #1;

        // Single write, zero wait states
        set_req(0, 1'b1, 1'b1, 10'd5, 32'hA5A5_1234, 4'hF);
        pready = 1'b1; prdata = 32'hDEAD_BEEF;
        cycle();
        req_valid = 2'b00;
        repeat (4) cycle();

        // Read with two wait states
        set_req(1, 1'b1, 1'b0, 10'd6, 32'h0, 4'h0);
        pready = 1'b0;
        cycle();
        req_valid = 2'b00;
        repeat (3) cycle();
        pready = 1'b1; prdata = 32'h0000_003C;
        repeat (3) cycle();

        // Contention: both held for four back-to-back transfers
        set_req(0, 1'b1, 1'b1, 10'h011, 32'h1111_0000, 4'h3);
        set_req(1, 1'b1, 1'b0, 10'h122, 32'h2222_0000, 4'hC);
        pready = 1'b1; prdata = 32'h5A5A_0001;
        repeat (12) cycle();
        req_valid = 2'b00;
        repeat (2) cycle();

        // Slave error, then a clean transfer
        set_req(0, 1'b1, 1'b1, 10'd9, 32'h0BAD_0009, 4'h1);
        pslverr = 1'b1;
        cycle();
        req_valid = 2'b00;
        repeat (3) cycle();
        pslverr = 1'b0;
        set_req(1, 1'b1, 1'b0, 10'h3FF, 32'h0, 4'h0);
        prdata = 32'h1234_5678;
        cycle();
        req_valid = 2'b00;
        repeat (4) cycle();

        // Timeout with pready stuck low, then a normal transfer
        set_req(1, 1'b1, 1'b1, 10'h2A0, 32'hFEED_0001, 4'h7);
        pready = 1'b0;
        cycle();
        req_valid = 2'b00;
        repeat (20) cycle();
        pready = 1'b1;
        set_req(0, 1'b1, 1'b0, 10'h001, 32'h0, 4'h0);
        prdata = 32'hCAFE_F00D;
        cycle();
        req_valid = 2'b00;
        repeat (4) cycle();

        // Reset in the middle of access wait states
        set_req(1, 1'b1, 1'b0, 10'h020, 32'h0, 4'h0);
        pready = 1'b0;
        cycle();
        req_valid = 2'b00;
        repeat (4) cycle();
        preset_n = 1'b0;
        #1;
        check("midrst_psel", psel, 0);
        check("midrst_penable", penable, 0);
        check("midrst_busy", busy, 0);
        reset_model();
        set_req(0, 1'b1, 1'b0, 10'h030, 32'h0, 4'h0);
        set_req(1, 1'b1, 1'b1, 10'h031, 32'h7777_0000, 4'hF);
        pready = 1'b1; prdata = 32'h0000_0AAA;
        @(posedge pclk);
        #1;
        check("midrst_rsp_valid", rsp_valid, 0);
        @(posedge pclk);
        #1;
        preset_n = 1'b1;
        repeat (8) cycle();
        req_valid = 2'b00;
        repeat (3) cycle();

        // Random traffic with periodic stuck-slave windows
        for (int c = 0; c < 3000; c++) begin
            drive_random((c % 200) >= 150);
            cycle();
        end

        req_valid = 2'b00;
        pready = 1'b1;
        repeat (10) cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/apb_sl_req_arbiter.md
Name: apb_sl_req_arbiter

Overview:
Two-requester APB master arbiter that shares the serial-link bridge register port (data/config/status registers) between a CPU-side requester (port 0) and a DMA-side requester (port 1). Each request is one simple valid/ready transfer. The block issues the APB setup and access phases, waits for pready, and returns read data or an error to the owning requester. Grants are round-robin, and a timeout guards against a stalled slave.

Parameters:
ADDR_WIDTH, 10, width of APB and requester addresses
TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles before forced termination; 0 disables the timeout
TO_CNT_WIDTH, 5, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
pclk  input  1  APB clock; all logic is on its rising edge
preset_n  input  1  reset, asynchronous, active-low
req_valid  input  2  per-requester request valid; bit i belongs to requester i
req_ready  output  2  per-requester accept strobe (combinational)
req_write  input  2  per-requester direction, 1 = write
req_addr  input  2*ADDR_WIDTH  per-requester address, packed with requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  input  64  per-requester write data, 32 bits each
req_strb  input  8  per-requester byte strobes, 4 bits each
rsp_valid  output  2  one-cycle completion pulse to the owning requester
rsp_rdata  output  32  read data, shared by both requesters; qualified by rsp_valid
rsp_err  output  1  error flag, shared; qualified by rsp_valid
busy  output  1  high while in SETUP or ACCESS
owner  output  1  index of the current or most recent granted requester
paddr  output  ADDR_WIDTH  APB address
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
pwdata  output  32  APB write data
pstrb  output  4  APB byte strobes
pready  input  1  APB slave ready
prdata  input  32  APB read data
pslverr  input  1  APB slave error

Behaviour:
- Reset values (asynchronous on preset_n low):
  - state=IDLE; psel, penable, pwrite = 0; paddr, pwdata, pstrb = 0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, owner=0.
  - Round-robin pointer last_grant=1, so requester 0 wins the first contention.
  - Timeout counter = 0.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE arbitration:
  - Only requester i valid: it wins.
  - Both valid: the requester other than last_grant wins.
- IDLE grant cycle:
  - req_ready[winner]=1 for exactly that cycle; req_ready is 0 in every other state and for the loser.
  - Capture winner's write, addr, wdata, strb into the APB output registers.
  - Set owner=winner and last_grant=winner; go to SETUP.
- SETUP (exactly 1 cycle): psel=1, penable=0; next state ACCESS.
- ACCESS: psel=1, penable=1. APB address and control outputs stay stable until the transfer ends. Completion conditions:
  - pready=1: transfer completes.
  - TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES-1 with pready=0: transfer completes with timeout.
  - pslverr is sampled only in the pready cycle.
- On completion, the next cycle is IDLE and the following are registered:
  - psel=0, penable=0.
  - rsp_valid[owner]=1 for one cycle.
  - rsp_rdata = prdata for a read; 0 for a write or a timeout.
  - rsp_err = pslverr, or 1 on timeout.
- Back-to-back transfers: a new grant may occur in the same IDLE cycle that rsp_valid is high. Minimum transfer period is 3 cycles (grant, SETUP, ACCESS with pready=1). Latency from grant to rsp_valid is 3 cycles plus the number of pready wait states.
- Timeout counter:
  - Cleared on entering ACCESS; increments each ACCESS cycle while pready=0.
  - Never wraps; terminates at TIMEOUT_CYCLES-1.
- Requester obligations:
  - Hold request fields stable while req_valid=1 and not yet accepted.
  - Deasserting req_valid before acceptance is permitted; no transfer is issued.
- Simultaneous events: if req_valid changes during SETUP or ACCESS, it is ignored until IDLE. Only one outstanding transfer exists at a time.
- Reset mid-transfer: psel and penable drop immediately (asynchronous), no rsp_valid is generated, and the pointer returns to last_grant=1.
- busy = (state != IDLE).

Test Plan:
- Single write, zero wait: req0 write addr=5, wdata=0xA5A5_1234, strb=4'hF, pready held 1 -> req_ready[0] in cycle T; psel=1/penable=0 at T+1; penable=1 at T+2; rsp_valid[0]=1, rsp_err=0, rsp_rdata=0 at T+3.
- Read with 2 wait states: req1 read addr=6, pready low for 2 ACCESS cycles, then prdata=0x0000_003C -> rsp_valid[1] at grant+5, rsp_rdata=0x3C, paddr=6 stable throughout ACCESS.
- Contention and fairness: both req_valid held continuously for 4 transfers after reset -> grant order 0,1,0,1; no req_ready to the loser; no idle gap beyond the 3-cycle period.
- Slave error: req0 write addr=9, pready=1 with pslverr=1 -> rsp_err=1 on rsp_valid[0]; next request is served normally.
- Timeout: TIMEOUT_CYCLES=16, pready held 0 -> ACCESS lasts exactly 16 cycles, then psel=0, rsp_err=1, rsp_rdata=0; a subsequent transfer with pready=1 completes cleanly.
- Reset mid-ACCESS: assert preset_n=0 during wait states -> psel=penable=0 immediately, rsp_valid never pulses; after release, simultaneous requests grant requester 0 first.
